// File: rtl/bc_round_ctrl.sv
// bc_round_ctrl: Bulls and Cows game sequencer.
// Draws a 3-digit secret from a free-running LFSR, validates and scores
// guesses serially, and keeps a per-try history for the renderer.
// Optional feature macro: BC_DEBUG_SECRET_EN (exposes the secret on oSecret
// and makes an all-F guess a reveal request that forces WIN).
module bc_round_ctrl #(
    parameter int unsigned MAX_TRIES = 8,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  iNum1,
    input  logic [3:0]  iNum2,
    input  logic [3:0]  iNum3,
    input  logic        iNumRdy,
    input  logic        iNewGame,
    input  logic [2:0]  iRow,
    output logic        oRowValid,
    output logic [11:0] oRowNum,
    output logic [1:0]  oRowBulls,
    output logic [1:0]  oRowCows,
    output logic [3:0]  oTries,
    output logic [1:0]  oState,
    output logic        oBusy,
    output logic        oErr,
    output logic [11:0] oSecret
);

    localparam int unsigned DIG_W = 4;
    localparam int unsigned ROW_W = 3;
    localparam int unsigned CNT_W = 2;
    localparam logic [3:0]  TRIES_LAST = 4'(MAX_TRIES);

    typedef enum logic [2:0] {
        S_GEN,
        S_IDLE,
        S_CHECK,
        S_SCORE,
        S_WRITE,
        S_WIN,
        S_LOSE
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [15:0]        r_lfsr;
    logic [DIG_W-1:0]   r_sec [0:2];
    logic [DIG_W-1:0]   r_g   [0:2];
    logic [CNT_W-1:0]   r_gen_cnt;
    logic [CNT_W-1:0]   r_idx;
    logic [CNT_W-1:0]   r_bulls;
    logic [CNT_W-1:0]   r_cows;
    logic [3:0]         r_tries;

    logic [11:0]        r_hist_num   [0:MAX_TRIES-1];
    logic [CNT_W-1:0]   r_hist_bulls [0:MAX_TRIES-1];
    logic [CNT_W-1:0]   r_hist_cows  [0:MAX_TRIES-1];
    logic [MAX_TRIES-1:0] r_hist_v;

    logic               r_err;
    logic               r_busy;
    logic [1:0]         r_ostate;

    logic               w_lfsr_fb;
    logic [DIG_W-1:0]   w_cand;
    logic               w_cand_ok;
    logic               w_guess_bad;
    logic               w_reveal;
    logic [DIG_W-1:0]   w_gd;
    logic               w_bull;
    logic               w_cow;
    logic               w_err_nxt;
    logic               w_busy_nxt;
    logic [1:0]         w_ostate_nxt;

    // LFSR feedback (taps 16,14,13,11) and candidate secret digit
    always_comb begin
        w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
        w_cand    = r_lfsr[3:0];
        w_cand_ok = (w_cand < 4'd10)
                 && ((r_gen_cnt < 2'd1) || (w_cand != r_sec[0]))
                 && ((r_gen_cnt < 2'd2) || (w_cand != r_sec[1]));
    end

    // Guess validity, reveal request and per-digit scoring
    always_comb begin
        w_guess_bad = (r_g[0] > 4'd9) || (r_g[1] > 4'd9) || (r_g[2] > 4'd9)
                   || (r_g[0] == r_g[1]) || (r_g[0] == r_g[2]) || (r_g[1] == r_g[2]);
`ifdef BC_DEBUG_SECRET_EN
        w_reveal = (iNum1 == 4'hF) && (iNum2 == 4'hF) && (iNum3 == 4'hF);
`else
        w_reveal = 1'b0;
`endif
        w_gd   = r_g[r_idx];
        w_bull = (w_gd == r_sec[r_idx]);
        w_cow  = !w_bull && ((w_gd == r_sec[0]) || (w_gd == r_sec[1]) || (w_gd == r_sec[2]));
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_GEN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state and next-cycle output values
    always_comb begin
        w_state_nxt  = r_state;
        w_err_nxt    = 1'b0;
        w_busy_nxt   = 1'b0;
        w_ostate_nxt = 2'b00;
        case (r_state)
            S_GEN: begin
                if (w_cand_ok && (r_gen_cnt == 2'd2)) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_IDLE: begin
                if (iNumRdy) begin
                    w_state_nxt = w_reveal ? S_WIN : S_CHECK;
                end
            end
            S_CHECK: begin
                if (w_guess_bad) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_SCORE;
                end
            end
            S_SCORE: begin
                if (r_idx == 2'd2) begin
                    w_state_nxt = S_WRITE;
                end
            end
            S_WRITE: begin
                if (r_bulls == 2'd3) begin
                    w_state_nxt = S_WIN;
                end else if ((r_tries + 4'd1) == TRIES_LAST) begin
                    w_state_nxt = S_LOSE;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_WIN:   w_state_nxt = S_WIN;
            S_LOSE:  w_state_nxt = S_LOSE;
            default: w_state_nxt = S_GEN;
        endcase
        if (iNewGame) begin
            w_state_nxt = S_GEN;
            w_err_nxt   = 1'b0;
        end
        case (w_state_nxt)
            S_GEN:   begin w_busy_nxt = 1'b1; w_ostate_nxt = 2'b11; end
            S_CHECK, S_SCORE, S_WRITE: w_busy_nxt = 1'b1;
            S_WIN:   w_ostate_nxt = 2'b01;
            S_LOSE:  w_ostate_nxt = 2'b10;
            default: w_ostate_nxt = 2'b00;
        endcase
    end

    // Registered status outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err    <= 1'b0;
            r_busy   <= 1'b1;
            r_ostate <= 2'b11;
        end else begin
            r_err    <= w_err_nxt;
            r_busy   <= w_busy_nxt;
            r_ostate <= w_ostate_nxt;
        end
    end

    // Datapath: LFSR, secret draw, guess latch, scoring and history write
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lfsr    <= LFSR_SEED;
            r_gen_cnt <= '0;
            r_idx     <= '0;
            r_bulls   <= '0;
            r_cows    <= '0;
            r_tries   <= '0;
            r_hist_v  <= '0;
            for (int unsigned i = 0; i < 3; i++) begin
                r_sec[i] <= '0;
                r_g[i]   <= '0;
            end
            for (int unsigned i = 0; i < MAX_TRIES; i++) begin
                r_hist_num[i]   <= '0;
                r_hist_bulls[i] <= '0;
                r_hist_cows[i]  <= '0;
            end
        end else begin
            r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
            if (iNewGame) begin
                r_tries   <= '0;
                r_hist_v  <= '0;
                r_gen_cnt <= '0;
            end else begin
                case (r_state)
                    S_GEN: begin
                        if (w_cand_ok) begin
                            r_sec[r_gen_cnt] <= w_cand;
                            r_gen_cnt        <= (r_gen_cnt == 2'd2) ? 2'd0 : r_gen_cnt + 2'd1;
                        end
                    end
                    S_IDLE: begin
                        if (iNumRdy) begin
                            r_g[0] <= iNum1;
                            r_g[1] <= iNum2;
                            r_g[2] <= iNum3;
                        end
                    end
                    S_CHECK: begin
                        r_bulls <= '0;
                        r_cows  <= '0;
                        r_idx   <= '0;
                    end
                    S_SCORE: begin
                        r_bulls <= r_bulls + 2'(w_bull);
                        r_cows  <= r_cows + 2'(w_cow);
                        r_idx   <= r_idx + 2'd1;
                    end
                    S_WRITE: begin
                        r_hist_num[r_tries[ROW_W-1:0]]   <= {r_g[0], r_g[1], r_g[2]};
                        r_hist_bulls[r_tries[ROW_W-1:0]] <= r_bulls;
                        r_hist_cows[r_tries[ROW_W-1:0]]  <= r_cows;
                        r_hist_v[r_tries[ROW_W-1:0]]     <= 1'b1;
                        r_tries                          <= r_tries + 4'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Combinational history read for the renderer
    always_comb begin
        oRowValid = 1'b0;
        oRowNum   = '0;
        oRowBulls = '0;
        oRowCows  = '0;
        if (32'(iRow) < MAX_TRIES) begin
            if (r_hist_v[iRow]) begin
                oRowValid = 1'b1;
                oRowNum   = r_hist_num[iRow];
                oRowBulls = r_hist_bulls[iRow];
                oRowCows  = r_hist_cows[iRow];
            end
        end
    end

    assign oTries = r_tries;
    assign oState = r_ostate;
    assign oBusy  = r_busy;
    assign oErr   = r_err;
`ifdef BC_DEBUG_SECRET_EN
    assign oSecret = {r_sec[0], r_sec[1], r_sec[2]};
`else
    assign oSecret = 12'h000;
`endif

endmodule

// File: doc/bc_round_ctrl.md
Name: bc_round_ctrl

Overview:
Game sequencer for the Bulls and Cows board, sitting between the PS/2 number front-end and the VGA game renderer.
- Draws a 3-digit secret with distinct digits from a free-running LFSR.
- Accepts guesses, validates them and scores bulls/cows serially, one digit per cycle.
- Keeps a per-try history the renderer reads row by row, and tracks tries and win/lose.

Parameters:
MAX_TRIES, 8, number of guesses per game (1..8; history depth)
LFSR_SEED, 16'hACE1, non-zero reset value of the 16-bit maximal LFSR (taps 16,14,13,11)

Ports:
clk  in  1  system clock (50 MHz)
reset  in  1  asynchronous, active-high reset
iNum1, iNum2, iNum3  in  4 each  guess digits, left to right; sampled only when iNumRdy=1
iNumRdy  in  1  single-cycle pulse: guess present
iNewGame  in  1  single-cycle pulse: abandon current game, start a new one
iRow  in  3  history row index requested by the renderer
oRowValid  out  1  history[iRow] holds a scored guess
oRowNum  out  12  {d1,d2,d3} of history[iRow]
oRowBulls  out  2  bulls of history[iRow]
oRowCows  out  2  cows of history[iRow]
oTries  out  4  scored guesses this game
oState  out  2  00 PLAY, 01 WIN, 10 LOSE, 11 GEN
oBusy  out  1  high in GEN, CHECK, SCORE and WRITE
oErr  out  1  one-cycle pulse: rejected guess
oSecret  out  12  secret {s1,s2,s3}; see Optional Feature

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high.
- Reset values:
  - FSM=GEN, LFSR=LFSR_SEED, oTries=0, all history valid bits=0.
  - oErr=0, oBusy=1, oState=11, secret=0.
- LFSR: steps every cycle in every state, including outside GEN.
- FSM states: GEN, IDLE, CHECK, SCORE, WRITE, WIN, LOSE.
- GEN:
  - Each cycle the candidate is lfsr[3:0].
  - Accept it into the next secret slot if it is <10 and differs from the slots already filled. Otherwise discard it.
  - After the 3rd accepted digit go to IDLE.
- IDLE: on iNumRdy, latch the three digits and go to CHECK. iNumRdy is ignored in every other state; there is no queuing.
- CHECK:
  - Reject the guess if any digit >9 or any two digits are equal. On reject, oErr=1 for exactly one cycle, return to IDLE, oTries and history unchanged.
  - Otherwise clear the bull/cow counters and go to SCORE.
- SCORE: 3 cycles, index i=0,1,2.
  - Bull if g[i]==s[i].
  - Otherwise cow if g[i]==s[j] for some j!=i.
- WRITE:
  - history[oTries] <= {guess, bulls, cows, valid=1}; oTries <= oTries+1.
  - If bulls==3, go to WIN.
  - Else if oTries+1==MAX_TRIES, go to LOSE.
  - Else go to IDLE.
- Latency: taking the clock edge that samples iNumRdy in IDLE as edge 0, the history row and oTries update at edge 5. The guess is back in IDLE, WIN or LOSE after edge 5.
- WIN / LOSE: hold; only iNewGame leaves these states.
- iNewGame, from any state:
  - At the next edge, clear all valid bits and oTries, then enter GEN.
  - Takes priority over a coincident iNumRdy.
  - The LFSR is not reseeded, so consecutive secrets differ.
- History read path:
  - oRow* is a combinational read of history[iRow].
  - If iRow >= MAX_TRIES, oRowValid=0 and oRowNum, oRowBulls, oRowCows are 0.
  - Rows with valid=0 also drive 0.
- oState mapping: PLAY for IDLE, CHECK, SCORE and WRITE; WIN; LOSE; GEN.
- Reset mid-operation: any state returns immediately to the reset values; any partially scored guess is lost.

Optional Feature:
BC_DEBUG_SECRET_EN
- Defined: oSecret drives the current secret. Additionally, a guess where all three digits are 4'hF is treated as a reveal request: it skips CHECK and SCORE, consumes no try, and forces WIN.
- Undefined: oSecret is constant 0. An all-F guess is rejected in CHECK like any other invalid guess.

Test Plan (BC_DEBUG_SECRET_EN defined unless stated):
1. Assert reset mid-SCORE, then release.
   -> oTries=0, all oRowValid=0, oState=11, oBusy=1.
   -> oState reaches 00 within 300 cycles.
   -> oSecret digits all <10 and pairwise distinct.
2. Secret 4,7,1; guess 1,7,9.
   -> At edge 5: row0 = {1,7,9}, bulls=1, cows=1; oTries=1; oState=00.
3. Guess 3,3,5, then guess 10,2,4.
   -> Each produces a one-cycle oErr.
   -> oTries stays 0; row0 stays invalid.
4. Guess equal to oSecret.
   -> bulls=3, oState=01.
   -> A later iNumRdy changes nothing.
5. MAX_TRIES=8 with 8 wrong guesses.
   -> oState=10, oTries=8, rows 0-7 valid.
   -> Then iNewGame: all rows invalid, oTries=0, oState=11.
6. iNumRdy during SCORE is ignored. iNewGame and iNumRdy in the same IDLE cycle start a new game with no row written.
   -> Without the macro: oSecret=0 and guess F,F,F gives an oErr pulse.
